// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, word geometry and requester IDs.
package dmem_arb_pkg;

  localparam int BPW = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ACK
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker with its own last-grant register.
// Ports: req[1:0], grant_en in; win, any_req out.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       win,
  output logic       any_req
);

  // Reset value 1 lets requester 0 win the first tie.
  logic last;

  assign any_req = |req;
  assign win     = (&req) ? ~last : req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (grant_en && any_req) begin
      last <= win;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a byte-wide data memory between CPU (0) and debug (1) ports.
// Ports: two req/we/addr/wdata/ack sets, rdata, busy, memory pins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam int WA_W = ADDR_W - 2;

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [1:0]      beat;
  logic            win_q;
  logic            we_q;
  logic [WA_W-1:0] wa_q;
  logic [31:0]     wd_q;
  logic [31:0]     rdata_q;

  logic            pick;
  logic            any_req;
  logic            sel_we;
  logic [WA_W-1:0] sel_wa;
  logic [31:0]     sel_wd;
  logic            unused_bits;

  // Byte offset and bits above the memory size are dropped,
  // which gives the modulo wrap of the word address.
  assign unused_bits = ^{addr0_i[31:ADDR_W], addr0_i[1:0],
                         addr1_i[31:ADDR_W], addr1_i[1:0]};

  rr_arb2 u_rr (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .req      ({req1_i, req0_i}),
    .grant_en (state == IDLE),
    .win      (pick),
    .any_req  (any_req)
  );

  assign sel_we = pick ? we1_i : we0_i;
  assign sel_wa = pick ? addr1_i[ADDR_W-1:2] : addr0_i[ADDR_W-1:2];
  assign sel_wd = pick ? wdata1_i : wdata0_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      beat    <= '0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            win_q <= pick;
            we_q  <= sel_we;
            wa_q  <= sel_wa;
            wd_q  <= sel_wd;
            beat  <= '0;
          end
        end
        XFER: begin
          // Little-endian assembly: beat k fills byte lane k.
          if (!we_q) begin
            rdata_q[{beat, 3'b000} +: 8] <= mem_rdata_i;
          end
          beat <= beat + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    ack0_o      = 1'b0;
    ack1_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        mem_we_o    = we_q;
        mem_addr_o  = {wa_q, beat};
        mem_wdata_o = wd_q[{beat, 3'b000} +: 8];
        if (beat == 2'(BPW - 1)) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack0_o    = (win_q == REQ_CPU);
        ack1_o    = (win_q == REQ_DBG);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_o  = (state != IDLE);
  assign rdata_o = rdata_q;

endmodule
